demux_18_deser: RTL and testbench
=================================

DEMUX_18_DESER -- requirements
Module: demux_18_deser

Interface
REQ-001 Parameter CONTINUOUS, default 0; 1 = return to COLLECT after each frame, 0 = return to IDLE.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin or restart a frame; sampled on clk.
REQ-005 din  input  1  serial data bit.
REQ-006 din_valid  input  1  din qualifier; one bit accepted per cycle when high in COLLECT.
REQ-007 s2, s1, s0  output  1 each  current demux select (slot index of next accepted bit), s2 = MSB.
REQ-008 y0..y7  output  1 each  registered parallel word; y0 = first bit of frame, y7 = last.
REQ-009 frame_done  output  1  one-cycle pulse: new word on y0..y7.
REQ-010 frame_abort  output  1  one-cycle pulse: partial frame discarded.
REQ-011 busy  output  1  high in COLLECT.

Function
REQ-012 States: IDLE, COLLECT.
REQ-013 IDLE: din/din_valid ignored; start=1 -> COLLECT with select = 000.
REQ-014 COLLECT, din_valid=1: din written to shadow slot[{s2,s1,s0}]; select increments by 1.
REQ-015 COLLECT, din_valid=0: select and shadow hold.
REQ-016 Accepted bit at select 111: select wraps to 000.
REQ-017 Same edge as REQ-016: shadow slots 0-6 plus that din transfer to y0..y7.
REQ-018 Same edge as REQ-016: frame_done asserted high for exactly the following cycle.
REQ-019 Same edge as REQ-016: next state COLLECT if CONTINUOUS=1, else IDLE.
REQ-020 Latency: y0..y7 and frame_done valid one clk after the edge sampling the 8th accepted bit.
REQ-021 y0..y7 hold their value until the next completed frame.
REQ-022 Aborted frames never modify y0..y7.
REQ-023 start=1 in COLLECT with select != 000 and no 8th bit accepted that edge: select -> 000, shadow discarded, frame_abort pulses 1 cycle, state stays COLLECT.
REQ-024 start=1 in COLLECT with select = 000: select stays 000, no frame_abort.
REQ-025 start=1 on the same edge as the 8th accepted bit: frame completes per REQ-017-018; next state COLLECT with select 000 regardless of CONTINUOUS; no frame_abort.
REQ-026 start with din_valid=1 in any state: that cycle's din not accepted; first bit is taken on a later cycle.
REQ-027 frame_done and frame_abort never high in the same cycle.
REQ-028 busy = 1 in COLLECT, 0 in IDLE.
REQ-029 {s2,s1,s0} always reflect the registered select; 000 in IDLE.

Reset
REQ-030 rst=1 forces immediately, without clk: state IDLE, select 000, shadow 0, y0..y7 = 0.
REQ-031 rst=1 also forces immediately: frame_done 0, frame_abort 0, busy 0.
REQ-032 rst mid-frame discards the partial frame without frame_abort.
REQ-033 Operation resumes on the first clk edge after rst deasserts; start is required even when CONTINUOUS=1.

Verification
REQ-034 Basic frame, CONTINUOUS=0: start, then 8 valid bits 1,0,0,0,0,0,0,0 -> y0=1, y1..y7=0, frame_done 1 cycle, state IDLE.
REQ-035 One-hot sweep: for k=0..7, frame with only bit k = 1, then its complement -> only yk = 1, then only yk = 0, matching the 8:1 mux select map.
REQ-036 Gapped din_valid: 8 bits 10110010 with din_valid low every other cycle -> y0..y7 = 1,0,1,1,0,0,1,0; select holds during gaps.
REQ-037 Abort: 3 bits accepted, then start -> frame_abort pulse, select 000, y0..y7 unchanged; next 8 bits (all 1) give y = 11111111.
REQ-038 CONTINUOUS=1: 16 back-to-back valid bits -> two frame_done pulses 8 cycles apart; busy stays high; select wraps 111 -> 000.
REQ-039 Async reset after 5 accepted bits, asserted between clk edges -> outputs zero before the next edge; no frame_abort; din ignored until start.

Source files
------------

// File: rtl/demux_18_deser.sv
// demux_18_deser: serial-to-parallel 1:8 deserializer.
// Bits accepted in COLLECT are demuxed into shadow slots selected by {s2,s1,s0}.
// The 8th accepted bit and shadow slots 0-6 are moved into the registered word y0..y7.
// A start in mid-frame discards the partial frame and pulses frame_abort.
module demux_18_deser #(
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic din,
  input  logic din_valid,
  output logic s2,
  output logic s1,
  output logic s0,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3,
  output logic y4,
  output logic y5,
  output logic y6,
  output logic y7,
  output logic frame_done,
  output logic frame_abort,
  output logic busy
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [6:0]  shadow_q, shadow_d;   // slot 7 is never stored: it goes straight to y7
  logic [7:0]  y_q, y_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic        last_bit_s;

  // Next-state, select, shadow and output-word logic.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    shadow_d   = shadow_q;
    y_d        = y_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    last_bit_s = (state_q == ST_COLLECT) && din_valid && (sel_q == 3'd7);
    case (state_q)
      ST_IDLE: begin
        sel_d = 3'd0;
        if (start) begin
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (last_bit_s) begin
          // 8th bit completes the frame even when start is also high.
          y_d      = {din, shadow_q};
          done_d   = 1'b1;
          sel_d    = 3'd0;
          shadow_d = 7'd0;
          if (start || CONTINUOUS) begin
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (start) begin
          // Restart: din of this cycle is not accepted.
          sel_d    = 3'd0;
          shadow_d = 7'd0;
          abort_d  = (sel_q != 3'd0);
        end else if (din_valid) begin
          for (int i = 0; i < 7; i++) begin
            if (sel_q == i[2:0]) begin
              shadow_d[i] = din;
            end else begin
              shadow_d[i] = shadow_q[i];
            end
          end
          sel_d = sel_q + 3'd1;
        end else begin
          sel_d    = sel_q;
          shadow_d = shadow_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sel_d    = 3'd0;
        shadow_d = 7'd0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= 3'd0;
      shadow_q <= 7'd0;
      y_q      <= 8'd0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
    end
  end

  assign {s2, s1, s0}  = sel_q;
  assign y0            = y_q[0];
  assign y1            = y_q[1];
  assign y2            = y_q[2];
  assign y3            = y_q[3];
  assign y4            = y_q[4];
  assign y5            = y_q[5];
  assign y6            = y_q[6];
  assign y7            = y_q[7];
  assign frame_done    = done_q;
  assign frame_abort   = abort_q;
  assign busy          = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_demux_18_deser.sv
// Testbench for demux_18_deser: one instance per CONTINUOUS setting, both driven
// by the same stimulus and compared against a frame-level reference model.
module tb_demux_18_deser;

  logic clk = 1'b0;
  logic rst, start, din, din_valid;

  logic [2:0] sel_a, sel_b;
  logic [7:0] y_a, y_b;
  logic       done_a, done_b, abort_a, abort_b, busy_a, busy_b;
  logic [13:0] obs_a, obs_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = CONTINUOUS 0, index 1 = CONTINUOUS 1.
  bit       m_active [2];
  int       m_cnt    [2];
  bit       m_bits   [2][8];
  bit [7:0] m_word   [2];
  bit       m_done   [2];
  bit       m_abort  [2];

  typedef struct {
    bit          st;
    bit          dv;
    bit          d;
    logic [13:0] exp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  demux_18_deser #(.CONTINUOUS(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .s2(sel_a[2]), .s1(sel_a[1]), .s0(sel_a[0]),
    .y0(y_a[0]), .y1(y_a[1]), .y2(y_a[2]), .y3(y_a[3]),
    .y4(y_a[4]), .y5(y_a[5]), .y6(y_a[6]), .y7(y_a[7]),
    .frame_done(done_a), .frame_abort(abort_a), .busy(busy_a)
  );

  demux_18_deser #(.CONTINUOUS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .s2(sel_b[2]), .s1(sel_b[1]), .s0(sel_b[0]),
    .y0(y_b[0]), .y1(y_b[1]), .y2(y_b[2]), .y3(y_b[3]),
    .y4(y_b[4]), .y5(y_b[5]), .y6(y_b[6]), .y7(y_b[7]),
    .frame_done(done_b), .frame_abort(abort_b), .busy(busy_b)
  );

  assign obs_a = {sel_a, y_a, done_a, abort_a, busy_a};
  assign obs_b = {sel_b, y_b, done_b, abort_b, busy_b};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_active[c] = 1'b0;
      m_cnt[c]    = 0;
      m_word[c]   = 8'h00;
      m_done[c]   = 1'b0;
      m_abort[c]  = 1'b0;
    end
  endfunction

  // Frame-level rules: count accepted bits; the 8th finishes the frame.
  function automatic void model_step(input int c, input bit st, input bit dv, input bit d);
    m_done[c]  = 1'b0;
    m_abort[c] = 1'b0;
    if (!m_active[c]) begin
      if (st) begin
        m_active[c] = 1'b1;
        m_cnt[c]    = 0;
      end
    end else if (dv && m_cnt[c] == 7) begin
      for (int i = 0; i < 7; i++) m_word[c][i] = m_bits[c][i];
      m_word[c][7] = d;
      m_done[c]    = 1'b1;
      m_cnt[c]     = 0;
      m_active[c]  = st || (c == 1);
    end else if (st) begin
      m_abort[c] = (m_cnt[c] != 0);
      m_cnt[c]   = 0;
    end else if (dv) begin
      m_bits[c][m_cnt[c]] = d;
      m_cnt[c]++;
    end
  endfunction

  function automatic logic [13:0] exp_obs(input int c);
    logic [2:0] s;
    s = 3'(m_cnt[c]);
    return {s, m_word[c], m_done[c], m_abort[c], m_active[c]};
  endfunction

  task automatic step(input bit st, input bit dv, input bit d);
    @(negedge clk);
    start = st; din_valid = dv; din = d;
    @(posedge clk);
    #1;
    model_step(0, st, dv, d);
    model_step(1, st, dv, d);
    check("model_c0", {2'b00, obs_a}, {2'b00, exp_obs(0)});
    check("model_c1", {2'b00, obs_b}, {2'b00, exp_obs(1)});
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_c0", {2'b00, obs_a}, 16'h0000);
    check("rst_async_c1", {2'b00, obs_b}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic void add(input bit st, input bit dv, input bit d, input logic [2:0] s,
                              input logic [7:0] y, input bit dn, input bit ab, input bit bz);
    vec_t v;
    v.st = st; v.dv = dv; v.d = d;
    v.exp = {s, y, dn, ab, bz};
    tbl.push_back(v);
  endfunction

  initial begin
    int done_pos[$];
    int busy_low;
    bit [7:0] pat;
    logic [2:0] sel_hold;

    rst = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0;
    model_reset();
    #12;
    check("reset_c0", {2'b00, obs_a}, 16'h0000);
    check("reset_c1", {2'b00, obs_b}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Directed table for the CONTINUOUS=0 instance.
    add(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 2; i < 8; i++) add(1'b0, 1'b1, 1'b0, 3'(i), 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0);   // basic frame done, back to IDLE
    add(1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0);   // IDLE ignores din
    add(1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0, 1'b0, 1'b1);   // start: din not taken
    add(1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0, 1'b0, 1'b1);   // start at select 0: no abort
    for (int i = 1; i < 4; i++) add(1'b0, 1'b1, 1'b1, 3'(i), 8'h01, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 3'd0, 8'h01, 1'b0, 1'b1, 1'b1);   // abort after 3 bits
    add(1'b0, 1'b0, 1'b0, 3'd0, 8'h01, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) add(1'b0, 1'b1, 1'b1, 3'(i), 8'h01, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].st, tbl[i].dv, tbl[i].d);
      check("vec", {2'b00, obs_a}, {2'b00, tbl[i].exp});
    end

    // start together with the 8th bit: frame completes, stays in COLLECT.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'(i & 1));
    step(1'b1, 1'b1, 1'b1);
    check("start_on_8th_flags", {13'd0, done_a, abort_a, busy_a}, 16'h0005);
    check("start_on_8th_sel", {13'd0, sel_a}, 16'h0000);

    // One-hot sweep and complement.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, (i == k));
      check("onehot", {8'd0, y_a}, 16'(1 << k));
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, (i != k));
      check("onecold", {8'd0, y_a}, {8'd0, ~8'(1 << k)});
    end

    // Gapped din_valid: select holds during gaps.
    pat = 8'h4D;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, pat[i]);
      if (i < 7) begin
        sel_hold = sel_a;
        step(1'b0, 1'b0, 1'b1);
        check("gap_hold", {13'd0, sel_a}, {13'd0, sel_hold});
      end
    end
    check("gapped_word", {8'd0, y_a}, 16'h004D);

    // CONTINUOUS=1: 16 back-to-back bits give two done pulses 8 cycles apart.
    step(1'b1, 1'b0, 1'b0);
    busy_low = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      if (done_b) done_pos.push_back(i);
      if (!busy_b) busy_low++;
    end
    check("cont_pulses", 16'(done_pos.size()), 16'd2);
    if (done_pos.size() == 2) begin
      check("cont_first", 16'(done_pos[0]), 16'd7);
      check("cont_spacing", 16'(done_pos[1] - done_pos[0]), 16'd8);
    end
    check("cont_busy", 16'(busy_low), 16'd0);

    // Async reset mid-frame, then din ignored until start.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
    async_reset();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("post_rst_idle_c1", {2'b00, obs_b}, 16'h0000);
    check("post_rst_idle_c0", {2'b00, obs_a}, 16'h0000);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
      if ((done_a && abort_a) || (done_b && abort_b)) begin
        check("done_abort_excl", 16'd1, 16'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
